fp_adder_special_pipe: RTL and testbench

//  Pipelined, multi-lane special-value stage placed before the FP adder datapath.
//  Per lane it classifies operands (NAN/INF/ZERO/NORMAL), applies add/sub, and builds the final special result.
//  It also raises a sticky invalid flag. Valid/ready handshake with a skid register gives full throughput under backpressure.
//  It replaces the combinational classifier; the downstream align/add stage consumes NORMAL lanes only.

---
 rtl/fp_adder_special_pipe_pkg.sv | 61 ++++++
 rtl/fp_adder_special_pipe_lane.sv | 94 +++++++++
 rtl/fp_adder_special_pipe.sv | 124 ++++++++++++
 tb/tb_fp_adder_special_pipe.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_adder_special_pipe_pkg.sv
// Shared FP format helpers and special-value codes for the adder front end.
// Format selectors, field widths, canonical qNaN and the per-lane class code.
package fp_adder_special_pipe_pkg;

    localparam int FP16 = 0;
    localparam int FP32 = 1;
    localparam int FP64 = 2;

    typedef enum logic [1:0] {
        SP_NORMAL = 2'd0,
        SP_ZERO   = 2'd1,
        SP_INF    = 2'd2,
        SP_NAN    = 2'd3
    } special_t;

    function automatic int fp_len(input int fmt);
        case (fmt)
            FP16:    return 16;
            FP64:    return 64;
            default: return 32;
        endcase
    endfunction

    function automatic int exp_len(input int fmt);
        case (fmt)
            FP16:    return 5;
            FP64:    return 11;
            default: return 8;
        endcase
    endfunction

    function automatic int mant_len(input int fmt);
        return fp_len(fmt) - 1 - exp_len(fmt);
    endfunction

    // Canonical quiet NaN, right-aligned in 64 bits:
    // sign 0, exponent all ones, mantissa MSB set, rest clear.
    function automatic logic [63:0] qnan(input int fmt);
        case (fmt)
            FP16:    return 64'h0000_0000_0000_7E00;
            FP64:    return 64'h7FF8_0000_0000_0000;
            default: return 64'h0000_0000_7FC0_0000;
        endcase
    endfunction

endpackage

`ifndef FP_ADDER_SPECIAL_MACROS
`define FP_ADDER_SPECIAL_MACROS
`define FP16 0
`define FP32 1
`define FP64 2
`define GET_FP_LEN(f) fp_adder_special_pipe_pkg::fp_len(f)
`define GET_EXP_LEN(f) fp_adder_special_pipe_pkg::exp_len(f)
`define GET_MANTISSA_LEN(f) fp_adder_special_pipe_pkg::mant_len(f)
`define GET_QNAN(f) fp_adder_special_pipe_pkg::qnan(f)
`define NORMAL 2'd0
`define ZERO 2'd1
`define INF 2'd2
`define NAN 2'd3
`endif

// File: rtl/fp_adder_special_pipe_lane.sv
// One lane of special-value handling: classify both operands, apply add/sub,
// build the special result word and the invalid bit. Purely combinational.
//   a, b    : operands          sub, rdn : subtract / round-down select
//   code    : NAN/INF/ZERO/NORMAL   result : special result (0 when NORMAL)
//   b_eff   : b with effective sign   invalid : sNaN or inf-inf in this lane
module fp_special_lane
    import fp_adder_special_pipe_pkg::*;
#(
    parameter int FMT = FP32,
    localparam int W = fp_len(FMT)
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    input  logic         rdn,
    output special_t     code,
    output logic [W-1:0] result,
    output logic [W-1:0] b_eff,
    output logic         invalid
);

    localparam int E = exp_len(FMT);
    localparam int M = mant_len(FMT);
    localparam logic [63:0] QN64 = qnan(FMT);
    localparam logic [W-1:0] QNAN = QN64[W-1:0];

    logic as;
    logic bs;
    logic a_ones;
    logic b_ones;
    logic a_mnz;
    logic b_mnz;
    logic a_nan;
    logic b_nan;
    logic a_inf;
    logic b_inf;
    logic a_zero;
    logic b_zero;
    logic a_snan;
    logic b_snan;
    logic inf_clash;

    assign as = a[W-1];
    assign bs = b[W-1] ^ sub;
    assign b_eff = {bs, b[W-2:0]};

    assign a_ones = &a[W-2:M];
    assign b_ones = &b[W-2:M];
    assign a_mnz = |a[M-1:0];
    assign b_mnz = |b[M-1:0];

    assign a_nan = a_ones & a_mnz;
    assign b_nan = b_ones & b_mnz;
    assign a_inf = a_ones & ~a_mnz;
    assign b_inf = b_ones & ~b_mnz;
    assign a_zero = ~|a[W-2:0];
    assign b_zero = ~|b[W-2:0];

    // Signalling NaN: quiet bit (mantissa MSB) clear.
    assign a_snan = a_nan & ~a[M-1];
    assign b_snan = b_nan & ~b[M-1];

    assign inf_clash = a_inf & b_inf & (as != bs);
    assign invalid = a_snan | b_snan | inf_clash;

    // Priority order matters here: NaN beats inf beats zero.
    always_comb begin
        code = SP_NORMAL;
        result = '0;
        if (a_nan || b_nan) begin
            code = SP_NAN;
            result = QNAN;
        end else if (a_inf && b_inf) begin
            if (inf_clash) begin
                code = SP_NAN;
                result = QNAN;
            end else begin
                code = SP_INF;
                result = {as, {E{1'b1}}, {M{1'b0}}};
            end
        end else if (a_inf) begin
            code = SP_INF;
            result = {as, {E{1'b1}}, {M{1'b0}}};
        end else if (b_inf) begin
            code = SP_INF;
            result = {bs, {E{1'b1}}, {M{1'b0}}};
        end else if (a_zero && b_zero) begin
            code = SP_ZERO;
            // Exact zero sum: +0 unless rounding down, where -0 wins.
            result = {rdn ? (as | bs) : (as & bs), {(W-1){1'b0}}};
        end
    end

endmodule

// File: rtl/fp_adder_special_pipe.sv
// Pipelined multi-lane special-value stage in front of the FP adder datapath.
// Ports: clk/rst, in_valid/in_ready + in_a/in_b/in_sub/in_rdn,
//   out_valid/out_ready + out_special/out_result/out_a/out_b,
//   flag_invalid (sticky) with flag_clr.
module fp_adder_special_pipe
    import fp_adder_special_pipe_pkg::*;
#(
    parameter int data_format = FP32,
    parameter int LANES = 1,
    localparam int W = fp_len(data_format)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*W-1:0]   in_a,
    input  logic [LANES*W-1:0]   in_b,
    input  logic                 in_sub,
    input  logic                 in_rdn,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*LANES-1:0]   out_special,
    output logic [LANES*W-1:0]   out_result,
    output logic [LANES*W-1:0]   out_a,
    output logic [LANES*W-1:0]   out_b,
    output logic                 flag_invalid,
    input  logic                 flag_clr
);

    typedef struct packed {
        logic [2*LANES-1:0] special;
        logic [LANES*W-1:0] result;
        logic [LANES*W-1:0] a;
        logic [LANES*W-1:0] b;
    } beat_t;

    logic [2*LANES-1:0] lane_special;
    logic [LANES*W-1:0] lane_result;
    logic [LANES*W-1:0] lane_b;
    logic [LANES-1:0]   lane_inv;

    beat_t new_beat;
    beat_t out_q;
    beat_t skid_q;
    logic  out_v;
    logic  skid_v;
    logic  flag_q;
    logic  accept;
    logic  drain;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        special_t code;

        fp_special_lane #(
            .FMT(data_format)
        ) u_lane (
            .a      (in_a[i*W +: W]),
            .b      (in_b[i*W +: W]),
            .sub    (in_sub),
            .rdn    (in_rdn),
            .code   (code),
            .result (lane_result[i*W +: W]),
            .b_eff  (lane_b[i*W +: W]),
            .invalid(lane_inv[i])
        );

        assign lane_special[2*i +: 2] = code;
    end

    assign new_beat = '{
        special: lane_special,
        result:  lane_result,
        a:       in_a,
        b:       lane_b
    };

    // in_ready depends only on registered skid state.
    assign in_ready = ~skid_v;
    assign accept = in_valid & ~skid_v;
    assign drain = ~out_v | out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_v <= 1'b0;
            skid_v <= 1'b0;
            out_q <= '0;
            skid_q <= '0;
        end else if (drain) begin
            // Skid is older than anything arriving now; it goes first.
            if (skid_v) begin
                out_q <= skid_q;
                out_v <= 1'b1;
                skid_v <= 1'b0;
            end else if (accept) begin
                out_q <= new_beat;
                out_v <= 1'b1;
            end else begin
                out_v <= 1'b0;
            end
        end else if (accept) begin
            skid_q <= new_beat;
            skid_v <= 1'b1;
        end
    end

    // Set wins over clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= 1'b0;
        end else if (accept && |lane_inv) begin
            flag_q <= 1'b1;
        end else if (flag_clr) begin
            flag_q <= 1'b0;
        end
    end

    assign out_valid = out_v;
    assign out_special = out_q.special;
    assign out_result = out_q.result;
    assign out_a = out_q.a;
    assign out_b = out_q.b;
    assign flag_invalid = flag_q;

endmodule

// File: tb/tb_fp_adder_special_pipe.sv
// Directed bench for fp_adder_special_pipe, FP32 with two lanes.
// Hand-computed vectors, handshake stall/order scenario and mid-run reset.
module tb_fp_adder_special_pipe;
    import fp_adder_special_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    logic        in_sub = 1'b0;
    logic        in_rdn = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_special;
    logic [63:0] out_result;
    logic [63:0] out_a;
    logic [63:0] out_b;
    logic        flag_invalid;
    logic        flag_clr = 1'b0;

    int total = 0;
    int bad = 0;

    fp_adder_special_pipe #(
        .data_format(FP32),
        .LANES      (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_sub      (in_sub),
        .in_rdn      (in_rdn),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_special (out_special),
        .out_result  (out_result),
        .out_a       (out_a),
        .out_b       (out_b),
        .flag_invalid(flag_invalid),
        .flag_clr    (flag_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present one beat, wait for acceptance, return on the negedge
    // right after the accepting edge (output now visible).
    task automatic send(input logic [63:0] a, input logic [63:0] b,
                        input logic s, input logic r);
        int n;
        n = 0;
        @(negedge clk);
        in_a = a;
        in_b = b;
        in_sub = s;
        in_rdn = r;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n == 10) chk("send_rdy", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    task automatic clr_flag();
        @(negedge clk);
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        #1;
    endtask

    initial begin
        int k;
        int rx;
        int first_stall;
        logic hold_v;
        logic [63:0] hold_a;

        #12;
        chk("rst_ovalid", 64'(out_valid), 64'd0);
        chk("rst_iready", 64'(in_ready), 64'd1);
        chk("rst_flag", 64'(flag_invalid), 64'd0);
        chk("rst_spec", 64'(out_special), 64'd0);
        chk("rst_res", out_result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // inf + -inf -> NaN invalid; 1.0 + 2.0 normal
        send(64'h3F800000_7F800000, 64'h40000000_FF800000, 1'b0, 1'b0);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_spec", 64'(out_special), 64'h3);
        chk("t1_res", out_result, 64'h00000000_7FC00000);
        chk("t1_flag", 64'(flag_invalid), 64'd1);
        chk("t1_a", out_a, 64'h3F800000_7F800000);
        clr_flag();
        chk("t1_clr", 64'(flag_invalid), 64'd0);

        // sNaN lane0, qNaN lane1
        send(64'h7FC00000_7F800001, 64'h3F800000_3F800000, 1'b0, 1'b0);
        chk("t2_spec", 64'(out_special), 64'hF);
        chk("t2_res", out_result, 64'h7FC00000_7FC00000);
        chk("t2_flag", 64'(flag_invalid), 64'd1);
        clr_flag();
        chk("t2_clr", 64'(flag_invalid), 64'd0);

        // qNaN alone is not invalid; subnormal + zero is normal
        send(64'h00000001_7FC00000, 64'h00000000_00000000, 1'b0, 1'b0);
        chk("t2b_spec", 64'(out_special), 64'h3);
        chk("t2b_res", out_result, 64'h00000000_7FC00000);
        chk("t2b_flag", 64'(flag_invalid), 64'd0);

        // zero sums under both rounding modes
        send(64'h80000000_00000000, 64'h80000000_80000000, 1'b0, 1'b0);
        chk("t3_spec0", 64'(out_special), 64'h5);
        chk("t3_res0", out_result, 64'h80000000_00000000);
        send(64'h80000000_00000000, 64'h80000000_80000000, 1'b0, 1'b1);
        chk("t3_spec1", 64'(out_special), 64'h5);
        chk("t3_res1", out_result, 64'h80000000_80000000);

        // subtract: inf-inf invalid, 1.0-inf -> -inf
        send(64'h3F800000_7F800000, 64'h7F800000_7F800000, 1'b1, 1'b0);
        chk("t4_spec", 64'(out_special), 64'hB);
        chk("t4_res", out_result, 64'hFF800000_7FC00000);
        chk("t4_b", out_b, 64'hFF800000_FF800000);
        chk("t4_flag", 64'(flag_invalid), 64'd1);
        clr_flag();
        send(64'hFF800000_7F800000, 64'h7F800000_FF800000, 1'b1, 1'b0);
        chk("t4b_spec", 64'(out_special), 64'hA);
        chk("t4b_res", out_result, 64'hFF800000_7F800000);
        chk("t4b_flag", 64'(flag_invalid), 64'd0);

        // back-to-back with backpressure in cycles 2..5
        @(negedge clk);
        #1;
        chk("t5_idle", 64'(out_valid), 64'd0);
        k = 0;
        rx = 0;
        first_stall = -1;
        hold_v = 1'b0;
        hold_a = '0;
        for (int cyc = 0; cyc < 40 && rx < 6; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 2 && cyc <= 5);
            in_valid = (k < 6);
            in_a = {32'(k), 32'h3F800000 + 32'(k)};
            in_b = {32'h0, 32'h40000000};
            in_sub = 1'b0;
            in_rdn = 1'b0;
            #1;
            if (hold_v) chk("t5_hold", out_a, hold_a);
            hold_v = out_valid && !out_ready;
            hold_a = out_a;
            if (!in_ready && first_stall < 0) first_stall = k;
            if (out_valid && out_ready) begin
                chk("t5_order", out_a, {32'(rx), 32'h3F800000 + 32'(rx)});
                rx++;
            end
            if (in_valid && in_ready) k++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("t5_count", 64'(rx), 64'd6);
        chk("t5_stall", 64'(first_stall), 64'd3);
        @(negedge clk);
        #1;
        chk("t5_drain", 64'(out_valid), 64'd0);

        // reset with output and skid both full
        @(negedge clk);
        out_ready = 1'b0;
        in_a = 64'h3F800000_7F800000;
        in_b = 64'h3F800000_FF800000;
        in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("t6_full_ov", 64'(out_valid), 64'd1);
        chk("t6_full_ir", 64'(in_ready), 64'd0);
        chk("t6_full_fl", 64'(flag_invalid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_ov", 64'(out_valid), 64'd0);
        chk("t6_ir", 64'(in_ready), 64'd1);
        chk("t6_fl", 64'(flag_invalid), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("t6_ghost", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
